// File: rtl/muldiv_pkg.sv
// Shared definitions for the MULT/DIV sequencer: state encoding and default sizes.
// The optional early-out path is enabled by defining MULDIV_EARLY_OUT_EN.
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 6;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_MULT = 3'd1;
  localparam logic [2:0] ST_DIV  = 3'd2;
  localparam logic [2:0] ST_FIX  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;
  localparam logic [2:0] ST_DZ   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_MULT = ST_MULT,
    S_DIV  = ST_DIV,
    S_FIX  = ST_FIX,
    S_DONE = ST_DONE,
    S_DZ   = ST_DZ
  } state_t;

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division step on unsigned magnitudes: shift in the next dividend
// bit, subtract the divisor when it fits, and report the quotient bit.
module div_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             din,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  // rem < divisor on entry, so the restored remainder always fits WIDTH bits.
  assign shifted  = {rem, din};
  assign q_bit    = (shifted >= {1'b0, divisor});
  assign diff     = shifted[WIDTH-1:0] - divisor;
  assign rem_next = q_bit ? diff : shifted[WIDTH-1:0];

endmodule

// File: rtl/muldiv_controller.sv
// Iterative signed multiply (Booth radix-2) / restoring signed divide feeding Hi/Lo.
// Define MULDIV_EARLY_OUT_EN to finish zero-operand operations in one cycle.
module muldiv_controller
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             hilo_write,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH:0]   acc_reg, m_reg;
  logic [WIDTH-1:0] q_reg;
  logic             qm1_reg;
  logic [WIDTH-1:0] rem_reg, dq_reg, dvs_reg;
  logic             sign_a_reg, sign_b_reg;
  logic [WIDTH-1:0] hi_reg, lo_reg;

  logic             last_step, mult_zero, div_a_zero, q_bit;
  logic [WIDTH:0]   acc_sum, acc_sh;
  logic [WIDTH-1:0] q_sh, rem_step, a_mag, b_mag;

`ifdef MULDIV_EARLY_OUT_EN
  assign mult_zero  = (op_a == '0) || (op_b == '0);
  assign div_a_zero = (op_a == '0);
`else
  assign mult_zero  = 1'b0;
  assign div_a_zero = 1'b0;
`endif

  assign last_step = (cnt_reg == CNT_W'(WIDTH - 1));
  assign a_mag     = op_a[WIDTH-1] ? -op_a : op_a;
  assign b_mag     = op_b[WIDTH-1] ? -op_b : op_b;

  // Accumulator carries one guard bit so subtracting the most negative multiplicand cannot overflow.
  always_comb begin
    acc_sum = acc_reg;
    case ({q_reg[0], qm1_reg})
      2'b01:   acc_sum = acc_reg + m_reg;
      2'b10:   acc_sum = acc_reg - m_reg;
      default: acc_sum = acc_reg;
    endcase
  end

  assign acc_sh = {acc_sum[WIDTH], acc_sum[WIDTH:1]};
  assign q_sh   = {acc_sum[0], q_reg[WIDTH-1:1]};

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem     (rem_reg),
    .din     (dq_reg[WIDTH-1]),
    .divisor (dvs_reg),
    .rem_next(rem_step),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (start_mult)     state_next = mult_zero ? S_DONE : S_MULT;
        else if (start_div) state_next = (op_b == '0) ? S_DZ : (div_a_zero ? S_DONE : S_DIV);
      end
      S_MULT:  if (last_step) state_next = S_DONE;
      S_DIV:   if (last_step) state_next = S_FIX;
      S_FIX:   state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      S_DZ:    state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg    <= '0;
      acc_reg    <= '0;
      m_reg      <= '0;
      q_reg      <= '0;
      qm1_reg    <= 1'b0;
      rem_reg    <= '0;
      dq_reg     <= '0;
      dvs_reg    <= '0;
      sign_a_reg <= 1'b0;
      sign_b_reg <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start_mult) begin
            cnt_reg <= '0;
            acc_reg <= '0;
            q_reg   <= op_a;
            qm1_reg <= 1'b0;
            m_reg   <= {op_b[WIDTH-1], op_b};
            if (mult_zero) begin
              hi_reg <= '0;
              lo_reg <= '0;
            end
          end else if (start_div) begin
            cnt_reg    <= '0;
            rem_reg    <= '0;
            dq_reg     <= a_mag;
            dvs_reg    <= b_mag;
            sign_a_reg <= op_a[WIDTH-1];
            sign_b_reg <= op_b[WIDTH-1];
            if ((op_b != '0) && div_a_zero) begin
              hi_reg <= '0;
              lo_reg <= '0;
            end
          end
        end
        S_MULT: begin
          acc_reg <= acc_sh;
          q_reg   <= q_sh;
          qm1_reg <= q_reg[0];
          cnt_reg <= cnt_reg + 1'b1;
          if (last_step) begin
            hi_reg <= acc_sh[WIDTH-1:0];
            lo_reg <= q_sh;
          end
        end
        S_DIV: begin
          rem_reg <= rem_step;
          dq_reg  <= {dq_reg[WIDTH-2:0], q_bit};
          cnt_reg <= cnt_reg + 1'b1;
        end
        S_FIX: begin
          lo_reg <= (sign_a_reg ^ sign_b_reg) ? -dq_reg : dq_reg;
          hi_reg <= sign_a_reg ? -rem_reg : rem_reg;
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state_reg == S_MULT) || (state_reg == S_DIV) || (state_reg == S_FIX);
  assign done       = (state_reg == S_DONE);
  assign hilo_write = (state_reg == S_DONE);
  assign div_zero   = (state_reg == S_DZ);
  assign hi_out     = hi_reg;
  assign lo_out     = lo_reg;

endmodule

// File: tb/tb_muldiv_controller.sv
// Self-checking bench for muldiv_controller: directed boundary cases plus random
// operands checked against plain signed 64-bit arithmetic.
module tb_muldiv_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_mult = 1'b0;
  logic        start_div = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy, done, hilo_write, div_zero;
  logic [31:0] hi_out, lo_out;

  int total = 0;
  int bad = 0;

  muldiv_controller dut (
    .clk       (clk),
    .reset     (reset),
    .start_mult(start_mult),
    .start_div (start_div),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .hilo_write(hilo_write),
    .div_zero  (div_zero),
    .hi_out    (hi_out),
    .lo_out    (lo_out)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mult(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p;
  endfunction

  // Returns {remainder, quotient}; 64-bit arithmetic keeps MIN/-1 well defined.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int exp_lat(input bit is_mult, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    if (is_mult && (a == 0 || b == 0)) return 1;
    if (!is_mult && a == 0) return 1;
`endif
    return is_mult ? 33 : 34;
  endfunction

  // Issues one start in the next IDLE-able cycle and waits (bounded) for done/div_zero.
  task automatic run_op(input logic sm, input logic sd, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_cycles, output int hw_bad, output logic saw_dz);
    @(negedge clk);
    start_mult = sm;
    start_div  = sd;
    op_a       = a;
    op_b       = b;
    lat = -1; busy_cycles = 0; hw_bad = 0; saw_dz = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      start_mult = 1'b0;
      start_div  = 1'b0;
      op_a       = $urandom;
      op_b       = $urandom;
      if (busy) busy_cycles++;
      if (hilo_write !== done) hw_bad++;
      if (done || div_zero) begin
        lat    = k;
        saw_dz = div_zero;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, hilo_write, div_zero} !== 4'b0 || hi_out !== 0 || lo_out !== 0) begin
      bad++;
      $display("FAIL reset_state: got busy=%b done=%b hw=%b dz=%b hi=%h lo=%h, want all 0",
               busy, done, hilo_write, div_zero, hi_out, lo_out);
    end
    reset = 1'b0;
  endtask

  task automatic test_mult_directed();
    int lat, bc, hw; logic dz;
    run_op(1'b1, 1'b0, 32'd7, 32'hFFFFFFFD, lat, bc, hw, dz);
    total++;
    if (lat !== 33) begin bad++; $display("FAIL mult_latency: got %0d want 33", lat); end
    total++;
    if (bc !== 32) begin bad++; $display("FAIL mult_busy_cycles: got %0d want 32", bc); end
    total++;
    if (hi_out !== 32'hFFFFFFFF || lo_out !== 32'hFFFFFFEB) begin
      bad++; $display("FAIL mult_7x-3: got %h_%h want ffffffff_ffffffeb", hi_out, lo_out);
    end
    total++;
    if (hw !== 0) begin bad++; $display("FAIL mult_hilo_write_eq_done: %0d cycles differ, want 0", hw); end
  endtask

  task automatic test_div_directed();
    int lat, bc, hw; logic dz;
    run_op(1'b0, 1'b1, 32'hFFFFFFF9, 32'd2, lat, bc, hw, dz);
    total++;
    if (lat !== 34) begin bad++; $display("FAIL div_latency: got %0d want 34", lat); end
    total++;
    if (bc !== 33) begin bad++; $display("FAIL div_busy_cycles: got %0d want 33", bc); end
    total++;
    if (hi_out !== 32'hFFFFFFFF || lo_out !== 32'hFFFFFFFD) begin
      bad++; $display("FAIL div_-7/2: got hi=%h lo=%h want hi=ffffffff lo=fffffffd", hi_out, lo_out);
    end
    run_op(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, lat, bc, hw, dz);
    total++;
    if (hi_out !== 32'h0 || lo_out !== 32'h80000000 || lat !== 34) begin
      bad++; $display("FAIL div_min_by_-1: got hi=%h lo=%h lat=%0d want hi=0 lo=80000000 lat=34",
                      hi_out, lo_out, lat);
    end
  endtask

  task automatic test_div_zero();
    int lat, bc, hw; logic dz;
    logic [31:0] hi_prev, lo_prev;
    logic [63:0] exp;
    hi_prev = hi_out;
    lo_prev = lo_out;
    run_op(1'b0, 1'b1, 32'h12345678, 32'h0, lat, bc, hw, dz);
    total++;
    if (lat !== 1 || dz !== 1'b1 || hilo_write !== 1'b0) begin
      bad++; $display("FAIL div_zero_pulse: got lat=%0d dz=%b hw=%b want 1 1 0", lat, dz, hilo_write);
    end
    total++;
    if (hi_out !== hi_prev || lo_out !== lo_prev) begin
      bad++; $display("FAIL div_zero_hold: got %h_%h want %h_%h", hi_out, lo_out, hi_prev, lo_prev);
    end
    // Next start issued in the cycle right after DZ.
    run_op(1'b1, 1'b0, 32'd1000, 32'hFFFFFF00, lat, bc, hw, dz);
    exp = ref_mult(32'd1000, 32'hFFFFFF00);
    total++;
    if (lat !== 33 || {hi_out, lo_out} !== exp) begin
      bad++; $display("FAIL after_dz_mult: got lat=%0d %h_%h want lat=33 %h", lat, hi_out, lo_out, exp);
    end
  endtask

  task automatic test_both_starts();
    int lat, bc, hw; logic dz;
    run_op(1'b1, 1'b1, 32'h80000000, 32'h80000000, lat, bc, hw, dz);
    total++;
    if (lat !== 33 || hi_out !== 32'h40000000 || lo_out !== 32'h0) begin
      bad++; $display("FAIL mult_priority: got lat=%0d %h_%h want lat=33 40000000_00000000",
                      lat, hi_out, lo_out);
    end
  endtask

  task automatic test_abort();
    int events = 0;
    int busy_seen = 0;
    @(negedge clk);
    start_mult = 1'b1; op_a = 32'h0000_1234; op_b = 32'h0000_5678;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      start_mult = 1'b0;
      start_div  = (k == 4);
      op_b       = (k == 4) ? 32'd0 : 32'd3;
      if (busy) busy_seen++;
      if (done || div_zero) events++;
      if (k == 9) reset = 1'b1;
    end
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (busy_seen !== 9) begin bad++; $display("FAIL abort_busy_before: got %0d want 9", busy_seen); end
    total++;
    if ({busy, done, hilo_write, div_zero} !== 4'b0 || hi_out !== 0 || lo_out !== 0) begin
      bad++; $display("FAIL abort_reset_state: got busy=%b done=%b hw=%b dz=%b hi=%h lo=%h want all 0",
                      busy, done, hilo_write, div_zero, hi_out, lo_out);
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done || hilo_write || div_zero || busy) events++;
    end
    total++;
    if (events !== 0) begin bad++; $display("FAIL abort_no_write: got %0d stray events want 0", events); end
  endtask

  task automatic test_early_out();
    int lat, bc, hw; logic dz;
    int want;
    run_op(1'b1, 1'b0, 32'h0, 32'h0BADBEEF, lat, bc, hw, dz);
    want = exp_lat(1'b1, 32'h0, 32'h0BADBEEF);
    total++;
    if (lat !== want || hi_out !== 0 || lo_out !== 0) begin
      bad++; $display("FAIL mult_zero_operand: got lat=%0d %h_%h want lat=%0d 0_0", lat, hi_out, lo_out, want);
    end
  endtask

  task automatic test_random_mult();
    int lat, bc, hw; logic dz;
    logic [31:0] a, b;
    logic [63:0] exp;
    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      b = $urandom;
      if (i == 0) a = 32'h7FFFFFFF;
      if (i == 1) b = 32'h0;
      exp = ref_mult(a, b);
      run_op(1'b1, 1'b0, a, b, lat, bc, hw, dz);
      total++;
      if ({hi_out, lo_out} !== exp || lat !== exp_lat(1'b1, a, b) || hw !== 0) begin
        bad++; $display("FAIL rand_mult %h*%h: got %h_%h lat=%0d want %h lat=%0d",
                        a, b, hi_out, lo_out, lat, exp, exp_lat(1'b1, a, b));
      end
    end
  endtask

  task automatic test_random_div();
    int lat, bc, hw; logic dz;
    logic [31:0] a, b;
    logic [63:0] exp;
    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      if (i % 4 == 1) b = -b;
      if (b == 0) b = 32'd5;
      if (i == 2) a = 32'h80000000;
      exp = ref_div(a, b);
      run_op(1'b0, 1'b1, a, b, lat, bc, hw, dz);
      total++;
      if ({hi_out, lo_out} !== exp || lat !== exp_lat(1'b0, a, b) || dz !== 1'b0) begin
        bad++; $display("FAIL rand_div %h/%h: got hi=%h lo=%h lat=%0d want hi=%h lo=%h lat=%0d",
                        a, b, hi_out, lo_out, lat, exp[63:32], exp[31:0], exp_lat(1'b0, a, b));
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult_directed();
    test_div_directed();
    test_div_zero();
    test_both_starts();
    test_abort();
    test_early_out();
    test_random_mult();
    test_random_div();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
